esc_bank_ctrl: RTL and testbench
================================

Name: esc_bank_ctrl

Overview:
Port controller for the 8-entry scalar register bank of the vector processor. It round-robin arbitrates several read requesters onto the bank's single read port and several write requesters onto its single write port. It returns tagged read data, and runs a clear sequencer that zeroes every scalar register on command. It sits between the decode/execute requesters and the scalar bank, and drives all bank control inputs.

Parameters:
NRD, 2, number of read requesters (>=2)
NWR, 2, number of write requesters (>=2)
DW, 8, scalar data width
AW, 3, scalar address width (2^AW registers)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req  in  NRD  per-requester read request, level, held until granted
rd_addr  in  NRD*AW  read addresses, requester i at [i*AW +: AW]
rd_gnt  out  NRD  one-hot read grant, combinational
rd_valid  out  1  read data valid, one cycle after grant
rd_id  out  max(1,$clog2(NRD))  index of requester owning rd_data
rd_data  out  DW  read data (= bank_eA)
wr_req  in  NWR  per-requester write request, level, held until granted
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*DW  write data
wr_gnt  out  NWR  one-hot write grant, combinational
clr_start  in  1  start clear sequence (sampled in IDLE only)
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse at end of clear
bank_dir_A  out  AW  to bank read address
bank_signal_read  out  1  to bank read enable
bank_dir_esc  out  AW  to bank write address
bank_data  out  DW  to bank write data
bank_signal_esc  out  1  to bank write enable
bank_eA  in  DW  from bank read data (registered by the bank on posedge)

Behaviour:
- Reset (async, rst_n=0): rd_valid=0, rd_id=0, clr_busy=0, clr_done=0, both RR pointers=0, FSM=IDLE, clear counter=0. Grants and bank enables are 0 while in reset.
- Bank timing: a read enabled in cycle t appears on bank_eA after the posedge ending t. The bank writes on the negedge inside cycle t. A same-address read and write in the same cycle therefore returns the new data. The controller adds no bypass.
- Read arbitration (FSM=IDLE): grant the first requester with rd_req=1 at or after rd_ptr, cyclically.
  - bank_signal_read=|rd_gnt; bank_dir_A=rd_addr of the granted requester.
  - On a posedge with a grant, rd_ptr takes the granted index+1 modulo NRD. With no grant, rd_ptr holds.
- Read return: registered rd_valid<=|rd_gnt and rd_id<=granted index. rd_data=bank_eA. Latency is exactly 1 cycle, with a throughput of one read per cycle.
- Write arbitration (FSM=IDLE): identical RR scheme with independent wr_ptr.
  - bank_signal_esc=|wr_gnt.
  - bank_dir_esc and bank_data come from the granted requester.
  - Ungranted requesters keep their request asserted.
- Requester rule: req, addr and data stay stable until gnt. Dropping req before gnt is legal and simply withdraws the request.
- FSM states IDLE, CLEAR, DONE:
  - IDLE: if clr_start=1, go to CLEAR with counter=0. clr_start has priority over any rd/wr requests in that cycle, but the grants for that cycle are still issued.
  - CLEAR: clr_busy=1, rd_gnt=0, wr_gnt=0, bank_signal_read=0. Drives bank_signal_esc=1, bank_dir_esc=counter, bank_data=0. The counter increments each cycle. When counter=2^AW-1, go to DONE. Duration is exactly 2^AW cycles.
  - DONE: clr_busy=0, clr_done=1 for one cycle, no grants. Next state is IDLE.
- clr_start in CLEAR/DONE is ignored and not queued.
- RR pointers do not move while in CLEAR/DONE.
- rd_valid goes 0 the cycle after the last IDLE grant.
- Reset during CLEAR: return immediately to IDLE. Registers are left partially cleared, and no clr_done is produced.
- Counter width is AW; it wraps only at exit from CLEAR.

Test Plan:
- Reset, then rd_req=2'b11 held with addresses 1 and 5 for 4 cycles -> rd_gnt 01,10,01,10. rd_valid=1 from cycle 2 with rd_id 0,1,0,1.
- wr_req=2'b11 with (addr 3, data 8'hAA) and (addr 3, data 8'h55), then read addr 3 -> writer 0 granted first, writer 1 next cycle, final read returns 8'h55.
- Same cycle: writer writes 8'h3C to addr 6 and reader reads addr 6 -> rd_valid next cycle with rd_data=8'h3C.
- Fill all regs with nonzero data, pulse clr_start:
  - clr_busy=1 for 8 cycles, bank_dir_esc 0..7 with bank_data=0.
  - All gnt=0 throughout, even with rd_req/wr_req asserted.
  - clr_done pulses once.
  - Reads of 0..7 then return 0.
- Assert rst_n=0 in cycle 4 of CLEAR -> clr_busy=0 immediately, no clr_done. Regs 0..2 (or 0..3) read 0, the rest keep their old values.
- clr_start re-pulsed during CLEAR -> exactly one 8-cycle sequence and one clr_done.

Source files
------------

// File: rtl/esc_bank_ctrl.sv
// esc_bank_ctrl
//   Port controller for the scalar register bank. Round-robin arbitrates NRD
//   read requesters onto the bank read port and NWR write requesters onto the
//   bank write port, returns tagged read data one cycle after grant, and runs
//   a clear sequencer that writes zero to every register on command.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rd_req/rd_addr     read requests (level) and packed addresses
//   rd_gnt             one-hot read grant (combinational)
//   rd_valid/rd_id     registered read-return valid and owner index
//   rd_data            read data, passed straight from bank_eA
//   wr_req/addr/data   write requests (level), packed addresses and data
//   wr_gnt             one-hot write grant (combinational)
//   clr_start          start a clear sequence (only honoured in IDLE)
//   clr_busy/clr_done  clear in progress / one-cycle completion pulse
//   bank_*             bank control outputs and registered read data input
module esc_bank_ctrl #(
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int DW  = 8,
  parameter int AW  = 3,
  localparam int RIW = (NRD > 1) ? $clog2(NRD) : 1,
  localparam int WIW = (NWR > 1) ? $clog2(NWR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD-1:0]    rd_req,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_gnt,
  output logic              rd_valid,
  output logic [RIW-1:0]    rd_id,
  output logic [DW-1:0]     rd_data,
  input  logic [NWR-1:0]    wr_req,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  output logic [NWR-1:0]    wr_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [AW-1:0]     bank_dir_A,
  output logic              bank_signal_read,
  output logic [AW-1:0]     bank_dir_esc,
  output logic [DW-1:0]     bank_data,
  output logic              bank_signal_esc,
  input  logic [DW-1:0]     bank_eA
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t         state_q, state_d;
  logic [RIW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           rd_valid_q, rd_valid_d;
  logic [RIW-1:0] rd_id_q, rd_id_d;
  logic           clr_busy_q, clr_busy_d;
  logic           clr_done_q, clr_done_d;

  logic           rd_found, wr_found;
  logic [RIW-1:0] rd_sel;
  logic [WIW-1:0] wr_sel;
  logic           arb_en;

  // Arbitration only runs in IDLE and is held off while reset is asserted.
  assign arb_en = rst_n && (state_q == IDLE);

  // Read round-robin: first requester at or after rd_ptr_q, cyclically.
  always_comb begin
    int idx;
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = int'(rd_ptr_q) + k;
      if (idx >= NRD) idx = idx - NRD;
      if (!rd_found && rd_req[idx]) begin
        rd_found = 1'b1;
        rd_sel   = RIW'(idx);
      end
    end
  end

  // Write round-robin with its own independent pointer.
  always_comb begin
    int idx;
    wr_found = 1'b0;
    wr_sel   = '0;
    for (int k = 0; k < NWR; k++) begin
      idx = int'(wr_ptr_q) + k;
      if (idx >= NWR) idx = idx - NWR;
      if (!wr_found && wr_req[idx]) begin
        wr_found = 1'b1;
        wr_sel   = WIW'(idx);
      end
    end
  end

  always_comb begin
    rd_gnt = '0;
    wr_gnt = '0;
    if (arb_en && rd_found) rd_gnt[rd_sel] = 1'b1;
    if (arb_en && wr_found) wr_gnt[wr_sel] = 1'b1;
  end

  assign bank_signal_read = |rd_gnt;
  assign bank_dir_A       = rd_addr[int'(rd_sel)*AW +: AW];

  // The clear sequencer owns the write port for the whole CLEAR state.
  always_comb begin
    if (state_q == CLEAR) begin
      bank_signal_esc = 1'b1;
      bank_dir_esc    = cnt_q;
      bank_data       = '0;
    end else begin
      bank_signal_esc = |wr_gnt;
      bank_dir_esc    = wr_addr[int'(wr_sel)*AW +: AW];
      bank_data       = wr_data[int'(wr_sel)*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_valid_d = |rd_gnt;
    rd_id_d    = rd_id_q;

    // Grants only exist in IDLE, so pointers are frozen in CLEAR/DONE.
    if (|rd_gnt) begin
      rd_id_d  = rd_sel;
      rd_ptr_d = (int'(rd_sel) == NRD - 1) ? '0 : rd_sel + RIW'(1);
    end
    if (|wr_gnt) begin
      wr_ptr_d = (int'(wr_sel) == NWR - 1) ? '0 : wr_sel + WIW'(1);
    end

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    clr_busy_d = (state_d == CLEAR);
    clr_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = bank_eA;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_esc_bank_ctrl.sv
// tb_esc_bank_ctrl
//   Directed bench for esc_bank_ctrl with a small behavioural bank model
//   (write on negedge, registered read on posedge). Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge.
module tb_esc_bank_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_req;
  logic [5:0]  rd_addr;
  logic [1:0]  rd_gnt;
  logic        rd_valid;
  logic [0:0]  rd_id;
  logic [7:0]  rd_data;
  logic [1:0]  wr_req;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_gnt;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic [2:0]  bank_dir_A;
  logic        bank_signal_read;
  logic [2:0]  bank_dir_esc;
  logic [7:0]  bank_data;
  logic        bank_signal_esc;
  logic [7:0]  bank_eA;

  int n_checks = 0;
  int n_errors = 0;

  esc_bank_ctrl #(.NRD(2), .NWR(2), .DW(8), .AW(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_gnt           (rd_gnt),
    .rd_valid         (rd_valid),
    .rd_id            (rd_id),
    .rd_data          (rd_data),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_gnt           (wr_gnt),
    .clr_start        (clr_start),
    .clr_busy         (clr_busy),
    .clr_done         (clr_done),
    .bank_dir_A       (bank_dir_A),
    .bank_signal_read (bank_signal_read),
    .bank_dir_esc     (bank_dir_esc),
    .bank_data        (bank_data),
    .bank_signal_esc  (bank_signal_esc),
    .bank_eA          (bank_eA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: writes land on the negedge, reads are registered on posedge.
  logic [7:0] mem [0:7];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    bank_eA = 8'h00;
  end
  always @(negedge clk) if (bank_signal_esc) mem[bank_dir_esc] <= bank_data;
  always @(posedge clk) if (bank_signal_read) bank_eA <= mem[bank_dir_A];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with requests already pending: no grants, no enables.
    rst_n     = 1'b0;
    rd_req    = 2'b11;
    rd_addr   = '0;
    wr_req    = 2'b11;
    wr_addr   = '0;
    wr_data   = 16'hFFFF;
    clr_start = 1'b0;
    @(negedge clk);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_bank_read", bank_signal_read, 0);
    chk("rst_bank_esc", bank_signal_esc, 0);
    next_cyc;
    rst_n = 1'b1;

    // Read round robin: both requesters held, addresses 1 and 5.
    wr_req  = 2'b00;
    rd_req  = 2'b11;
    rd_addr = {3'd5, 3'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_rd_gnt", rd_gnt, (i % 2 == 1) ? 2 : 1);
      chk("rr_dir_A", bank_dir_A, (i % 2 == 1) ? 5 : 1);
      chk("rr_rd_valid", rd_valid, (i > 0) ? 1 : 0);
      if (i > 0) chk("rr_rd_id", rd_id, (i - 1) % 2);
      next_cyc;
    end
    rd_req = 2'b00;
    @(negedge clk);
    chk("rr_tail_gnt", rd_gnt, 0);
    chk("rr_tail_valid", rd_valid, 1);
    chk("rr_tail_id", rd_id, 1);
    next_cyc;
    @(negedge clk);
    chk("rr_idle_valid", rd_valid, 0);
    $display("phase read_rr done");
    next_cyc;

    // Two writers to addr 3, then read it back.
    wr_req  = 2'b11;
    wr_addr = {3'd3, 3'd3};
    wr_data = {8'h55, 8'hAA};
    @(negedge clk);
    chk("wr0_gnt", wr_gnt, 1);
    chk("wr0_esc", bank_signal_esc, 1);
    chk("wr0_dir", bank_dir_esc, 3);
    chk("wr0_data", bank_data, 8'hAA);
    next_cyc;
    wr_req = 2'b10;
    @(negedge clk);
    chk("wr1_gnt", wr_gnt, 2);
    chk("wr1_data", bank_data, 8'h55);
    next_cyc;
    wr_req  = 2'b00;
    rd_req  = 2'b01;
    rd_addr = {3'd0, 3'd3};
    @(negedge clk);
    chk("wr_rb_gnt", rd_gnt, 1);
    chk("wr_rb_dir", bank_dir_A, 3);
    next_cyc;
    rd_req = 2'b00;
    @(negedge clk);
    chk("wr_rb_valid", rd_valid, 1);
    chk("wr_rb_id", rd_id, 0);
    chk("wr_rb_data", rd_data, 8'h55);
    $display("phase write_rr done");
    next_cyc;

    // Same-cycle write and read of addr 6 returns the new value.
    wr_req  = 2'b01;
    wr_addr = {3'd0, 3'd6};
    wr_data = {8'h00, 8'h3C};
    rd_req  = 2'b01;
    rd_addr = {3'd0, 3'd6};
    @(negedge clk);
    chk("same_wr_gnt", wr_gnt, 1);
    chk("same_rd_gnt", rd_gnt, 1);
    next_cyc;
    wr_req = 2'b00;
    rd_req = 2'b00;
    @(negedge clk);
    chk("same_valid", rd_valid, 1);
    chk("same_data", rd_data, 8'h3C);
    $display("phase same_cycle done");
    next_cyc;

    // Fill every register through writer 1 (wr_ptr now points at 1).
    for (int i = 0; i < 8; i++) begin
      wr_req  = 2'b10;
      wr_addr = {i[2:0], 3'd0};
      wr_data = {8'(16 + i), 8'h00};
      @(negedge clk);
      chk("fill_gnt", wr_gnt, 2);
      next_cyc;
    end
    wr_req    = 2'b00;
    clr_start = 1'b1;
    @(negedge clk);
    chk("clr_start_busy", clr_busy, 0);
    next_cyc;

    // CLEAR: requests held and clr_start re-pulsed, all must be ignored.
    for (int k = 0; k < 8; k++) begin
      clr_start = (k == 3);
      rd_req    = 2'b11;
      wr_req    = 2'b11;
      wr_addr   = {3'd7, 3'd7};
      wr_data   = 16'hFFFF;
      @(negedge clk);
      chk("clr_busy", clr_busy, 1);
      chk("clr_esc", bank_signal_esc, 1);
      chk("clr_dir", bank_dir_esc, k);
      chk("clr_data", bank_data, 0);
      chk("clr_rd_gnt", rd_gnt, 0);
      chk("clr_wr_gnt", wr_gnt, 0);
      chk("clr_bank_read", bank_signal_read, 0);
      chk("clr_done_early", clr_done, 0);
      next_cyc;
    end
    clr_start = 1'b0;
    @(negedge clk);
    chk("done_busy", clr_busy, 0);
    chk("done_pulse", clr_done, 1);
    chk("done_rd_gnt", rd_gnt, 0);
    chk("done_wr_gnt", wr_gnt, 0);
    chk("done_esc", bank_signal_esc, 0);
    next_cyc;
    rd_req = 2'b00;
    wr_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_done", clr_done, 0);
      chk("post_busy", clr_busy, 0);
      next_cyc;
    end

    // Readback via requester 1; rd_ptr kept its pre-clear value of 1.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        rd_req  = (i == 0) ? 2'b11 : 2'b10;
        rd_addr = {i[2:0], 3'd0};
      end else begin
        rd_req = 2'b00;
      end
      @(negedge clk);
      if (i < 8) chk("clr_rb_gnt", rd_gnt, 2);
      if (i > 0) begin
        chk("clr_rb_valid", rd_valid, 1);
        chk("clr_rb_id", rd_id, 1);
        chk("clr_rb_data", rd_data, 0);
      end
      next_cyc;
    end
    $display("phase clear done");

    // Refill through writer 0, then reset in the fourth CLEAR cycle.
    for (int i = 0; i < 8; i++) begin
      wr_req  = 2'b01;
      wr_addr = {3'd0, i[2:0]};
      wr_data = {8'h00, 8'(128 + i)};
      @(negedge clk);
      chk("fill2_gnt", wr_gnt, 1);
      next_cyc;
    end
    wr_req    = 2'b00;
    clr_start = 1'b1;
    @(negedge clk);
    next_cyc;
    clr_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rclr_busy", clr_busy, 1);
      chk("rclr_dir", bank_dir_esc, k);
      next_cyc;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rclr_busy_rst", clr_busy, 0);
    chk("rclr_esc_rst", bank_signal_esc, 0);
    chk("rclr_done_rst", clr_done, 0);
    next_cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rclr_no_done", clr_done, 0);
      chk("rclr_no_busy", clr_busy, 0);
      next_cyc;
    end

    // Registers 0..2 were cleared before reset; 3..7 keep their fill value.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        rd_req  = 2'b01;
        rd_addr = {3'd0, i[2:0]};
      end else begin
        rd_req = 2'b00;
      end
      @(negedge clk);
      if (i < 8) chk("rclr_rb_gnt", rd_gnt, 1);
      if (i > 0) begin
        chk("rclr_rb_valid", rd_valid, 1);
        chk("rclr_rb_data", rd_data, (i - 1 < 3) ? 0 : 128 + i - 1);
      end
      next_cyc;
    end
    $display("phase reset_in_clear done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
